// File: rtl/cordic_range_ctrl.sv
// cordic_range_ctrl: folds request operands into the CORDIC convergence range, launches the core, unfolds its results
//
// Ports:
//   clk, rst (async, active-low)      clock and reset
//   in_valid/in_ready, in_mode        request handshake; mode 0 = rotation, 1 = vectoring
//   in_x, in_y, in_z                  signed Q15 request operands
//   cor_start, cor_mode, cor_x/y/z    one-cycle launch pulse and folded operands to the core
//   cor_done, cor_x/y/z_res           core completion pulse and raw results
//   out_valid/out_ready               result handshake
//   out_x/y/z, out_mode, out_err      unfolded results, mode echo, range/timeout error
module cordic_range_ctrl #(
    parameter int WIDTH   = 32,
    parameter int PI      = 102944,
    parameter int HALF_PI = 51472,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_mode,
    input  logic signed [WIDTH-1:0] in_x,
    input  logic signed [WIDTH-1:0] in_y,
    input  logic signed [WIDTH-1:0] in_z,
    output logic                    cor_start,
    output logic                    cor_mode,
    output logic signed [WIDTH-1:0] cor_x,
    output logic signed [WIDTH-1:0] cor_y,
    output logic signed [WIDTH-1:0] cor_z,
    input  logic                    cor_done,
    input  logic signed [WIDTH-1:0] cor_x_res,
    input  logic signed [WIDTH-1:0] cor_y_res,
    input  logic signed [WIDTH-1:0] cor_z_res,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_x,
    output logic signed [WIDTH-1:0] out_y,
    output logic signed [WIDTH-1:0] out_z,
    output logic                    out_mode,
    output logic                    out_err
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, OUTPUT} state_t;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic signed [WIDTH-1:0] PI_W  = WIDTH'(PI);
    localparam logic signed [WIDTH-1:0] NPI_W = -WIDTH'(PI);
    localparam logic signed [WIDTH-1:0] HP_W  = WIDTH'(HALF_PI);
    localparam logic signed [WIDTH-1:0] NHP_W = -WIDTH'(HALF_PI);

    // Sign-extend by one bit; a disagreement between the top two bits means overflow, clamp toward its sign.
    function automatic logic signed [WIDTH-1:0] sat_add(input logic signed [WIDTH-1:0] a, b);
        logic signed [WIDTH:0] s;
        s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        return (s[WIDTH] != s[WIDTH-1]) ? {s[WIDTH], {(WIDTH-1){~s[WIDTH]}}} : s[WIDTH-1:0];
    endfunction

    function automatic logic signed [WIDTH-1:0] sat_neg(input logic signed [WIDTH-1:0] a);
        return (a == {1'b1, {(WIDTH-1){1'b0}}}) ? {1'b0, {(WIDTH-1){1'b1}}} : -a;
    endfunction

    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic flag, ysign, range_err, timeout;
    logic rot_hi, rot_lo, fold_flag, range_bad;
    logic signed [WIDTH-1:0] fold_x, fold_y, fold_z, res_x, res_y, res_z;

    assign timeout = cnt == CW'(TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = in_valid ? LAUNCH : IDLE;
            LAUNCH:  nxt = WAIT;
            WAIT:    nxt = (cor_done || timeout) ? OUTPUT : WAIT;
            OUTPUT:  nxt = out_ready ? IDLE : OUTPUT;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state == IDLE;
        cor_start = state == LAUNCH;
        out_valid = state == OUTPUT;
    end

    // Rotation folds z by +-pi (which negates x/y of the result); vectoring mirrors a left-half-plane vector.
    always_comb begin
        rot_hi    = in_z > HP_W;
        rot_lo    = in_z < NHP_W;
        fold_flag = in_mode ? in_x[WIDTH-1] : (rot_hi || rot_lo);
        fold_x    = (in_mode && in_x[WIDTH-1]) ? sat_neg(in_x) : in_x;
        fold_y    = (in_mode && in_x[WIDTH-1]) ? sat_neg(in_y) : in_y;
        fold_z    = in_mode ? in_z : rot_hi ? sat_add(in_z, NPI_W) : rot_lo ? sat_add(in_z, PI_W) : in_z;
        range_bad = !in_mode && (in_z > PI_W || in_z < NPI_W);
    end

    // Mirrored vectors get pi added back toward the side the original y lay on.
    always_comb begin
        res_x = (!cor_mode && flag) ? sat_neg(cor_x_res) : cor_x_res;
        res_y = (!cor_mode && flag) ? sat_neg(cor_y_res) : cor_y_res;
        res_z = (cor_mode && flag) ? sat_add(cor_z_res, ysign ? NPI_W : PI_W) : cor_z_res;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cor_mode  <= 1'b0;
            cor_x     <= '0;
            cor_y     <= '0;
            cor_z     <= '0;
            flag      <= 1'b0;
            ysign     <= 1'b0;
            range_err <= 1'b0;
            cnt       <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_z     <= '0;
            out_mode  <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                cor_mode  <= in_mode;
                cor_x     <= fold_x;
                cor_y     <= fold_y;
                cor_z     <= fold_z;
                flag      <= fold_flag;
                ysign     <= in_y[WIDTH-1];
                range_err <= range_bad;
                out_mode  <= in_mode;
            end
            cnt <= (state == WAIT) ? cnt + CW'(1) : '0;
            if (state == WAIT && cor_done) begin
                out_x   <= res_x;
                out_y   <= res_y;
                out_z   <= res_z;
                out_err <= range_err;
            end else if (state == WAIT && timeout) begin
                out_x   <= '0;
                out_y   <= '0;
                out_z   <= '0;
                out_err <= 1'b1;
            end
        end
    end
endmodule

// File: doc/cordic_range_ctrl.md
CORDIC_RANGE_CTRL -- requirements
Module: cordic_range_ctrl

Interface
REQ-001 Parameters, SHALL be: WIDTH, 32, datapath width; PI, 102944, pi in Q15 radians; HALF_PI, 51472, pi/2 in Q15 radians; TIMEOUT, 64, max WAIT cycles.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low: asserting it (low) resets all state immediately, regardless of clk.
REQ-004 in_valid / in_ready  input / output  1 / 1  request handshake; transfer occurs when both are high on a rising edge.
REQ-005 in_mode  input  1  0 = rotation, 1 = vectoring.
REQ-006 in_x, in_y, in_z  input  WIDTH each  signed Q15 request operands.
REQ-007 cor_start  output  1  one-cycle start pulse to the CORDIC core.
REQ-008 cor_mode, cor_x, cor_y, cor_z  output  1, WIDTH x3  folded operands to the core.
REQ-009 cor_done  input  1  core completion pulse; cor_x_res, cor_y_res, cor_z_res  input  WIDTH each  core results.
REQ-010 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-011 out_x, out_y, out_z  output  WIDTH each  unfolded results; out_mode  output  1  echo of in_mode; out_err  output  1  range or timeout error.

Function
REQ-012 FSM SHALL have states IDLE, LAUNCH, WAIT, OUTPUT; in_ready SHALL be 1 only in IDLE.
REQ-013 IDLE: on in_valid, SHALL capture operands, compute fold, go to LAUNCH.
REQ-014 LAUNCH: cor_start SHALL be 1 for exactly this one cycle; next state WAIT; cor_mode/x/y/z SHALL be held stable from LAUNCH through the end of WAIT.
REQ-015 WAIT: on cor_done high, SHALL capture and unfold results, go to OUTPUT; out_valid SHALL rise on the edge after cor_done is sampled.
REQ-016 WAIT: a cycle counter SHALL cap the wait; if TIMEOUT cycles elapse without cor_done, go to OUTPUT with out_x = out_y = out_z = 0 and out_err = 1.
REQ-017 OUTPUT: out_valid = 1, all out_* stable; on out_ready, go to IDLE; cor_done arriving outside WAIT SHALL be ignored.
REQ-018 Rotation fold: z > HALF_PI -> cor_z = z - PI, negate flag set.
REQ-019 Rotation fold: z < -HALF_PI -> cor_z = z + PI, negate flag set.
REQ-020 Rotation fold: otherwise cor_z = z, flag clear.
REQ-021 Rotation fold: cor_x = in_x, cor_y = in_y, passed unmodified.
REQ-022 Rotation unfold: out_x/out_y = cor_x_res/cor_y_res, negated if flag set; out_z = cor_z_res.
REQ-023 Vectoring fold: in_x < 0 -> cor_x = -in_x, cor_y = -in_y, flag set; otherwise pass-through; cor_z = in_z.
REQ-024 Vectoring unfold: out_x = cor_x_res (core gain ~1.6468 not removed); out_y = cor_y_res.
REQ-025 Vectoring unfold: out_z = cor_z_res + PI if flag set and in_y >= 0, cor_z_res - PI if flag set and in_y < 0, cor_z_res if flag clear.
REQ-026 Negation SHALL saturate: negating -2^(WIDTH-1) yields 2^(WIDTH-1)-1; all add/sub SHALL be WIDTH-bit signed with saturation, no wrap.
REQ-027 Rotation with in_z outside [-PI, PI] SHALL still be folded and processed, with out_err = 1.
REQ-028 Minimum latency from in handshake to out_valid SHALL be 3 cycles plus core latency; throughput is one request in flight.

Reset
REQ-029 While rst is low, state SHALL be IDLE with in_ready = 1; cor_start, out_valid, out_err, out_mode = 0; cor_* and out_x/y/z = 0; counter and flag = 0.
REQ-030 Reset asserted mid-WAIT or mid-OUTPUT SHALL abort the transaction with no out_valid; a core cor_done arriving after reset release SHALL be ignored.

Verification
REQ-031 Rotation in_z=102944, in_x=19898, real core -> cor_z=0, out_x in [-32772,-32764], out_y in [-4,4], out_err=0.
REQ-032 Rotation in_z=-102944 -> cor_z=0, flag set, results match REQ-031; in_z=120000 -> out_err=1.
REQ-033 Vectoring in_x=-16384, in_y=0 -> cor_x=16384, cor_y=0; out_z=102944+-4; out_x in [26977,26985].
REQ-034 out_ready low 10 cycles after out_valid -> out_valid held, outputs stable, in_ready=0, second in_valid not accepted.
REQ-035 Stub core never asserts cor_done -> out_valid 64 cycles after entering WAIT, out_err=1, outputs 0.
REQ-036 rst low during WAIT, then stub cor_done after release -> no out_valid, in_ready=1, cor_start=0.
